vga_scan_out: RTL

- Raster timing generator and pixel output stage for the VGA path of the D8M camera design.
- Issues row/col coordinates to the RGB processing stage and accepts its processed RGB after a fixed latency.
- Aligns HS, VS and BLANK_N to that pixel data and drives the ADV7123 DAC pins.
- Sits between the pixel processor and the board VGA connector; all timing runs on a pixel clock enable.

---
 rtl/vga_scan_out.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// VGA raster timing generator and DAC output stage with PIPE_LAT-deep sync/blank alignment.
// Optional colour-bar test pattern is enabled by defining VGA_SCAN_TEST_PATTERN_EN.
module vga_scan_out #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_LAT = 0
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEN,
`ifdef VGA_SCAN_TEST_PATTERN_EN
  input  logic        iPatSel,
`endif
  output logic [12:0] oCol,
  output logic [12:0] oRow,
  output logic        oActive,
  output logic        oFrameStart,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N
);

  localparam int unsigned CNT_W   = 13;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Delay-line word: {[col[9:7]], blank_n, vs, hs}
  localparam int unsigned B_HS  = 0;
  localparam int unsigned B_VS  = 1;
  localparam int unsigned B_BN  = 2;
`ifdef VGA_SCAN_TEST_PATTERN_EN
  localparam int unsigned B_BAR = 3;
  localparam int unsigned DLY_W = 6;
`else
  localparam int unsigned DLY_W = 3;
`endif
  localparam logic [DLY_W-1:0] DLY_RST = DLY_W'(3'b011);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_hs_raw;
  logic             w_vs_raw;
  logic [DLY_W-1:0] w_raw;
  logic [DLY_W-1:0] w_dly;
  logic [7:0]       w_r;
  logic [7:0]       w_g;
  logic [7:0]       w_b;

  // Raster counters; v advances on h wrap
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (iEN) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  assign oCol        = r_h_cnt;
  assign oRow        = r_v_cnt;
  assign oActive     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign oFrameStart = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign oVGA_SYNC_N = 1'b0;

  assign w_hs_raw = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E));
  assign w_vs_raw = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E));

`ifdef VGA_SCAN_TEST_PATTERN_EN
  assign w_raw = {r_h_cnt[9:7], oActive, w_vs_raw, w_hs_raw};
`else
  assign w_raw = {oActive, w_vs_raw, w_hs_raw};
`endif

  // Flags ride a PIPE_LAT-deep shift register so they meet the returning pixel
  generate
    if (PIPE_LAT == 0) begin : g_no_dly
      assign w_dly = w_raw;
    end else begin : g_dly
      localparam int unsigned SR_W = PIPE_LAT * DLY_W;
      logic [SR_W-1:0] r_sr;

      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          r_sr <= {PIPE_LAT{DLY_RST}};
        end else if (iEN) begin
          r_sr <= SR_W'({r_sr, w_raw});
        end
      end

      assign w_dly = r_sr[SR_W-1 -: DLY_W];
    end
  endgenerate

  // Colour select; blanking overrides both pixel and pattern sources
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_dly[B_BN]) begin
`ifdef VGA_SCAN_TEST_PATTERN_EN
      if (iPatSel) begin
        case (w_dly[B_BAR +: 3])
          3'd0: begin w_r = 8'hFF; w_g = 8'hFF; w_b = 8'hFF; end
          3'd1: begin w_r = 8'hFF; w_g = 8'hFF; w_b = 8'h00; end
          3'd2: begin w_r = 8'h00; w_g = 8'hFF; w_b = 8'hFF; end
          3'd3: begin w_r = 8'h00; w_g = 8'hFF; w_b = 8'h00; end
          3'd4: begin w_r = 8'hFF; w_g = 8'h00; w_b = 8'hFF; end
          default: begin w_r = 8'h00; w_g = 8'h00; w_b = 8'h00; end
        endcase
      end else begin
        w_r = iR;
        w_g = iG;
        w_b = iB;
      end
`else
      w_r = iR;
      w_g = iG;
      w_b = iB;
`endif
    end
  end

  // DAC output register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else if (iEN) begin
      oVGA_R       <= w_r;
      oVGA_G       <= w_g;
      oVGA_B       <= w_b;
      oVGA_HS      <= w_dly[B_HS];
      oVGA_VS      <= w_dly[B_VS];
      oVGA_BLANK_N <= w_dly[B_BN];
    end
  end

endmodule
